// File: rtl/norm_ctrl.sv
// norm_ctrl: row sequencer between psum/output buffers and the normalizer.
// Keeps exactly one row in flight and aborts on a stalled beat stream.
module norm_ctrl #(
   parameter int COL     = 8,
   parameter int BW_PSUM = 16,
   parameter int W_OUT   = 16,
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        len,
   input  logic [ADDR_W-1:0]        base_rd,
   input  logic [ADDR_W-1:0]        base_wr,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     mem_ren,
   output logic [ADDR_W-1:0]        mem_raddr,
   input  logic [COL*BW_PSUM-1:0]   mem_rdata,
   output logic                     norm_s_valid,
   output logic [COL*BW_PSUM-1:0]   norm_psum,
   input  logic                     norm_valid,
   input  logic [W_OUT-1:0]         norm_data,
   output logic                     mem_wen,
   output logic [ADDR_W-1:0]        mem_waddr,
   output logic [COL*W_OUT-1:0]     mem_wdata
);

   localparam int KW  = (COL > 1) ? $clog2(COL) : 1;
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam int PW  = COL * BW_PSUM;
   localparam int RW  = COL * W_OUT;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      LAT,
      ISSUE,
      WAIT,
      WB
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] base_rd_q, base_rd_d;
   logic [ADDR_W-1:0] base_wr_q, base_wr_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic [KW-1:0]     k_q, k_d;
   logic [WDW-1:0]    wd_q, wd_d;
   logic [PW-1:0]     psum_q, psum_d;
   logic [RW-1:0]     row_q, row_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              ren_q, ren_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              sval_q, sval_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [RW-1:0]     wdata_q, wdata_d;

   // Next-state, datapath and registered-output decode for the sequencer.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      base_rd_d = base_rd_q;
      base_wr_d = base_wr_q;
      i_d       = i_q;
      k_d       = k_q;
      wd_d      = wd_q;
      psum_d    = psum_q;
      row_d     = row_q;
      err_d     = err_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d     = len;
               base_rd_d = base_rd;
               base_wr_d = base_wr;
               err_d     = 1'b0;
               i_d       = '0;
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            state_d = LAT;
         end
         LAT: begin
            psum_d  = mem_rdata;
            state_d = ISSUE;
         end
         ISSUE: begin
            k_d     = '0;
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (norm_valid) begin
               row_d[k_q*W_OUT +: W_OUT] = norm_data;
               k_d  = k_q + KW'(1);
               wd_d = '0;
               if (k_q == KW'(COL - 1)) begin
                  state_d = WB;
               end
            end else if (wd_q == WDW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         WB: begin
            if (i_q == len_q - ADDR_W'(1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               i_d     = i_q + ADDR_W'(1);
               state_d = RD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A beat with no row open is dropped but remembered as an error.
      if (norm_valid && (state_q != WAIT)) begin
         err_d = 1'b1;
      end

      busy_d  = (state_d != IDLE);
      ren_d   = (state_d == RD);
      sval_d  = (state_d == ISSUE);
      wen_d   = (state_d == WB);
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (state_d == RD) begin
         raddr_d = base_rd_d + i_d;
      end
      if (state_d == WB) begin
         waddr_d = base_wr_d + i_d;
         wdata_d = row_d;
      end
   end

   // State and output registers; reset drops the job with no done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         base_rd_q <= '0;
         base_wr_q <= '0;
         i_q       <= '0;
         k_q       <= '0;
         wd_q      <= '0;
         psum_q    <= '0;
         row_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ren_q     <= 1'b0;
         raddr_q   <= '0;
         sval_q    <= 1'b0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         base_rd_q <= base_rd_d;
         base_wr_q <= base_wr_d;
         i_q       <= i_d;
         k_q       <= k_d;
         wd_q      <= wd_d;
         psum_q    <= psum_d;
         row_q     <= row_d;
         err_q     <= err_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         ren_q     <= ren_d;
         raddr_q   <= raddr_d;
         sval_q    <= sval_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign mem_ren      = ren_q;
   assign mem_raddr    = raddr_q;
   assign norm_s_valid = sval_q;
   assign norm_psum    = psum_q;
   assign mem_wen      = wen_q;
   assign mem_waddr    = waddr_q;
   assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_norm_ctrl.sv
// tb_norm_ctrl: directed bench for the norm_ctrl row sequencer.
// Bench plays psum SRAM and normalizer; expectations are hand-derived.
module tb_norm_ctrl;

   localparam int COL = 8;
   localparam int BWP = 16;
   localparam int WO  = 16;
   localparam int AW  = 6;
   localparam int TO  = 1024;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              start = 1'b0;
   logic [AW-1:0]     len = '0;
   logic [AW-1:0]     base_rd = '0;
   logic [AW-1:0]     base_wr = '0;
   logic              busy, done, err;
   logic              mem_ren;
   logic [AW-1:0]     mem_raddr;
   logic [COL*BWP-1:0] mem_rdata = '0;
   logic              norm_s_valid;
   logic [COL*BWP-1:0] norm_psum;
   logic              norm_valid = 1'b0;
   logic [WO-1:0]     norm_data = '0;
   logic              mem_wen;
   logic [AW-1:0]     mem_waddr;
   logic [COL*WO-1:0] mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int busy_n  = 0;

   int                 done_c[$];
   int                 wen_c[$];
   logic [AW-1:0]      wa_q[$];
   logic [COL*WO-1:0]  wd_q[$];
   int                 ren_c[$];
   logic [AW-1:0]      ra_q[$];
   int                 sv_c[$];
   logic [COL*BWP-1:0] ps_q[$];

   norm_ctrl #(
      .COL(COL), .BW_PSUM(BWP), .W_OUT(WO),
      .ADDR_W(AW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .len(len), .base_rd(base_rd), .base_wr(base_wr),
      .busy(busy), .done(done), .err(err),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata),
      .norm_s_valid(norm_s_valid), .norm_psum(norm_psum),
      .norm_valid(norm_valid), .norm_data(norm_data),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;

   function automatic logic [COL*BWP-1:0] psum_pat(
      input logic [AW-1:0] a);
      logic [COL*BWP-1:0] v;
      v = '0;
      for (int l = 0; l < COL; l++)
         v[l*BWP +: BWP] = {8'(a), 8'(l + 1)};
      return v;
   endfunction

   function automatic logic [COL*WO-1:0] row_exp(
      input int dbase, input int r);
      logic [COL*WO-1:0] v;
      v = '0;
      for (int j = 0; j < COL; j++)
         v[j*WO +: WO] = 16'(dbase + r*COL + j);
      return v;
   endfunction

   // SRAM read model and event monitor, sampling the cycle just ended.
   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= psum_pat(mem_raddr);
      if (done) done_c.push_back(cyc);
      if (mem_wen) begin
         wen_c.push_back(cyc);
         wa_q.push_back(mem_waddr);
         wd_q.push_back(mem_wdata);
      end
      if (mem_ren) begin
         ren_c.push_back(cyc);
         ra_q.push_back(mem_raddr);
      end
      if (norm_s_valid) begin
         sv_c.push_back(cyc);
         ps_q.push_back(norm_psum);
      end
      if (busy) busy_n++;
      cyc++;
   end

   task automatic clr();
      done_c.delete(); wen_c.delete(); wa_q.delete();
      wd_q.delete(); ren_c.delete(); ra_q.delete();
      sv_c.delete(); ps_q.delete();
      busy_n = 0;
   endtask

   task automatic run_job(
      input int ln, input int brd, input int bwr,
      input int dbase, input int stop_row, input int stop_beat,
      input bit mid_start,
      output int start_cyc, output int last_beat, output bit to);
      to = 1'b0;
      last_beat = 0;
      @(negedge clk);
      start = 1'b1;
      len = AW'(ln); base_rd = AW'(brd); base_wr = AW'(bwr);
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < ln; r++) begin
         for (int w = 0; w < 20 && !norm_s_valid; w++)
            @(negedge clk);
         if (!norm_s_valid) begin
            to = 1'b1;
            return;
         end
         @(negedge clk);
         for (int j = 0; j < COL; j++) begin
            if (r == stop_row && j == stop_beat) begin
               norm_valid = 1'b0;
               return;
            end
            norm_valid = 1'b1;
            norm_data = 16'(dbase + r*COL + j);
            start = mid_start && r == 0 && j == 2;
            if (start) begin
               len = 6'd7; base_rd = 6'd33; base_wr = 6'd44;
            end
            last_beat = cyc;
            @(negedge clk);
         end
         norm_valid = 1'b0;
         start = 1'b0;
      end
   endtask

   task automatic wait_done(input int lim, output bit to);
      to = 1'b1;
      for (int w = 0; w < lim; w++) begin
         if (done_c.size() != 0) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({busy, done, err, mem_ren, mem_wen, norm_s_valid}
          !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 000000",
            {busy, done, err, mem_ren, mem_wen, norm_s_valid});
      end
      n_tests++;
      if ({mem_raddr, mem_waddr, mem_wdata, norm_psum} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got nonzero want 0");
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_row();
      int sc, lb;
      bit to, to2;
      clr();
      run_job(1, 3, 5, 10, -1, 0, 1'b0, sc, lb, to);
      wait_done(10, to2);
      n_tests++;
      if ({to, to2} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_tmo: got %b want 00", {to, to2});
         return;
      end
      n_tests++;
      if (wen_c.size() !== 1 || wa_q[0] !== 6'd5) begin
         n_fail++;
         $display("FAIL single_waddr: got n=%0d a=%0d want 1/5",
            wen_c.size(), wa_q[0]);
      end
      n_tests++;
      if (wd_q[0] !== row_exp(10, 0)) begin
         n_fail++;
         $display("FAIL single_wdata: got %h want %h",
            wd_q[0], row_exp(10, 0));
      end
      n_tests++;
      if (ra_q.size() !== 1 || ra_q[0] !== 6'd3 ||
          ren_c[0] !== sc + 1) begin
         n_fail++;
         $display("FAIL single_rd: got a=%0d c=%0d want 3/%0d",
            ra_q[0], ren_c[0], sc + 1);
      end
      n_tests++;
      if (sv_c.size() !== 1 || sv_c[0] !== sc + 3 ||
          ps_q[0] !== psum_pat(6'd3)) begin
         n_fail++;
         $display("FAIL single_issue: got c=%0d want %0d",
            sv_c[0], sc + 3);
      end
      n_tests++;
      if (wen_c[0] !== lb + 1 || done_c[0] !== wen_c[0] + 1) begin
         n_fail++;
         $display("FAIL single_tim: got wen=%0d done=%0d want %0d/%0d",
            wen_c[0], done_c[0], lb + 1, lb + 2);
      end
      n_tests++;
      if ({err, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_err: got %b want 00", {err, busy});
      end
   endtask

   task automatic test_multi_wrap();
      int sc, lb;
      bit to, to2;
      logic [AW-1:0] era[4];
      era[0] = 6'd62; era[1] = 6'd63; era[2] = 6'd0; era[3] = 6'd1;
      clr();
      run_job(4, 62, 60, 100, -1, 0, 1'b0, sc, lb, to);
      wait_done(10, to2);
      n_tests++;
      if ({to, to2} !== 2'b00 || wen_c.size() !== 4 ||
          ra_q.size() !== 4 || sv_c.size() !== 4) begin
         n_fail++;
         $display("FAIL multi_cnt: got w=%0d r=%0d s=%0d want 4",
            wen_c.size(), ra_q.size(), sv_c.size());
         return;
      end
      for (int r = 0; r < 4; r++) begin
         n_tests++;
         if (ra_q[r] !== era[r] || ps_q[r] !== psum_pat(era[r]) ||
             wa_q[r] !== AW'(60 + r) ||
             wd_q[r] !== row_exp(100, r)) begin
            n_fail++;
            $display("FAIL multi_row%0d: got ra=%0d wa=%0d want %0d/%0d",
               r, ra_q[r], wa_q[r], era[r], 60 + r);
         end
      end
      for (int r = 0; r < 3; r++) begin
         n_tests++;
         if (ren_c[r+1] !== wen_c[r] + 1 ||
             sv_c[r+1] !== ren_c[r+1] + 2) begin
            n_fail++;
            $display("FAIL multi_gap%0d: got ren=%0d want %0d",
               r, ren_c[r+1], wen_c[r] + 1);
         end
      end
      n_tests++;
      if (done_c.size() !== 1 || done_c[0] !== wen_c[3] + 1) begin
         n_fail++;
         $display("FAIL multi_done: got %0d want %0d",
            done_c[0], wen_c[3] + 1);
      end
   endtask

   task automatic test_len_zero();
      int sc, lb;
      bit to, to2;
      clr();
      run_job(0, 7, 9, 0, -1, 0, 1'b0, sc, lb, to);
      wait_done(5, to2);
      repeat (3) @(negedge clk);
      n_tests++;
      if (to2 !== 1'b0 || done_c.size() !== 1 ||
          done_c[0] !== sc + 1) begin
         n_fail++;
         $display("FAIL zero_done: got n=%0d c=%0d want 1/%0d",
            done_c.size(), done_c[0], sc + 1);
      end
      n_tests++;
      if (busy_n !== 0 || ren_c.size() !== 0 ||
          wen_c.size() !== 0 || sv_c.size() !== 0) begin
         n_fail++;
         $display("FAIL zero_quiet: got busy=%0d ren=%0d want 0/0",
            busy_n, ren_c.size());
      end
   endtask

   task automatic test_timeout();
      int sc, lb;
      bit to, to2;
      clr();
      run_job(2, 4, 8, 300, 0, 3, 1'b0, sc, lb, to);
      wait_done(TO + 20, to2);
      n_tests++;
      if ({to, to2} !== 2'b00 || done_c[0] !== lb + TO + 1) begin
         n_fail++;
         $display("FAIL tmo_done: got %0d want %0d",
            done_c[0], lb + TO + 1);
      end
      n_tests++;
      if ({err, busy} !== 2'b10 || wen_c.size() !== 0) begin
         n_fail++;
         $display("FAIL tmo_err: got e/b=%b wen=%0d want 10/0",
            {err, busy}, wen_c.size());
      end
      clr();
      run_job(1, 4, 8, 400, -1, 0, 1'b0, sc, lb, to);
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_clr: got %b want 0", err);
      end
      wait_done(10, to2);
      n_tests++;
      if (to2 !== 1'b0 || wen_c.size() !== 1 ||
          wd_q[0] !== row_exp(400, 0) || err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_next: got wen=%0d err=%b want 1/0",
            wen_c.size(), err);
      end
   endtask

   task automatic test_spurious_mid_start();
      int sc, lb;
      bit to, to2;
      @(negedge clk);
      norm_valid = 1'b1;
      norm_data = 16'hdead;
      @(negedge clk);
      norm_valid = 1'b0;
      n_tests++;
      if ({err, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL spur_err: got %b want 10", {err, busy});
      end
      clr();
      run_job(2, 10, 20, 200, -1, 0, 1'b1, sc, lb, to);
      wait_done(10, to2);
      repeat (10) @(negedge clk);
      n_tests++;
      if ({to, to2} !== 2'b00 || wen_c.size() !== 2 ||
          ren_c.size() !== 2 || done_c.size() !== 1) begin
         n_fail++;
         $display("FAIL mid_cnt: got w=%0d r=%0d d=%0d want 2/2/1",
            wen_c.size(), ren_c.size(), done_c.size());
         return;
      end
      n_tests++;
      if (wa_q[0] !== 6'd20 || wa_q[1] !== 6'd21 ||
          ra_q[1] !== 6'd11 || wd_q[1] !== row_exp(200, 1)) begin
         n_fail++;
         $display("FAIL mid_data: got wa=%0d,%0d want 20,21",
            wa_q[0], wa_q[1]);
      end
      n_tests++;
      if ({err, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL mid_err: got %b want 00", {err, busy});
      end
   endtask

   task automatic test_reset_mid();
      int sc, lb;
      bit to, to2;
      clr();
      run_job(3, 0, 8, 50, 1, 2, 1'b0, sc, lb, to);
      n_tests++;
      if (to !== 1'b0 || busy !== 1'b1 || wen_c.size() !== 1) begin
         n_fail++;
         $display("FAIL rmid_pre: got busy=%b wen=%0d want 1/1",
            busy, wen_c.size());
      end
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, done, err, mem_ren, mem_raddr, mem_wen, mem_waddr,
           mem_wdata, norm_s_valid, norm_psum} !== '0) begin
         n_fail++;
         $display("FAIL rmid_async: got b=%b ra=%0d want 0",
            busy, mem_raddr);
      end
      @(negedge clk);
      reset_n = 1'b1;
      clr();
      repeat (4) @(negedge clk);
      n_tests++;
      if (done_c.size() !== 0 || busy_n !== 0) begin
         n_fail++;
         $display("FAIL rmid_quiet: got done=%0d want 0",
            done_c.size());
      end
      run_job(2, 30, 40, 600, -1, 0, 1'b0, sc, lb, to);
      wait_done(10, to2);
      n_tests++;
      if ({to, to2} !== 2'b00 || wen_c.size() !== 2 ||
          wa_q[1] !== 6'd41 || wd_q[0] !== row_exp(600, 0) ||
          wd_q[1] !== row_exp(600, 1) || err !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_next: got wen=%0d err=%b want 2/0",
            wen_c.size(), err);
      end
   endtask

   initial begin
      test_reset();
      test_single_row();
      test_multi_wrap();
      test_len_zero();
      test_timeout();
      test_spurious_mid_start();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
